// File: rtl/mux_pkg.sv
// Shared constants and sizing helpers for the registered N-channel multiplexer.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Counter width that never collapses to zero bits (DWELL=1 still needs a register).
  function automatic int cnt_width(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/mux_nx1.sv
// Combinational N-to-1 selector; out-of-range indices return zero.
module mux_nx1
  import mux_pkg::*;
#(
  parameter int N  = 16,
  parameter int W  = 1,
  parameter int SW = clog2(N)
) (
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0]  idx,
  output logic [W-1:0]   out
);

  always_comb begin
    out = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SW'(k)) out = in[k*W +: W];
    end
  end

endmodule

// File: rtl/mux_seq_nx1.sv
// Registered N-channel mux with direct-select and auto-scan modes.
// With DWELL=1 the channel moves every cycle, so out_valid stays low for the whole scan.
module mux_seq_nx1
  import mux_pkg::*;
#(
  parameter int N     = 16,
  parameter int W     = 1,
  parameter int SW    = clog2(N),
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0]  sel,
  input  logic           load,
  input  logic           mode,
  output logic [W-1:0]   out,
  output logic           out_valid,
  output logic [SW-1:0]  ch,
  output logic           wrap,
  output logic           sel_err
);

  localparam int             CW       = cnt_width(DWELL);
  localparam logic [SW-1:0]  LAST_CH  = SW'(N - 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(DWELL - 1);
  localparam logic [SW:0]    N_EXT    = (SW + 1)'(N);

  logic [CW-1:0] cnt, cnt_next;
  logic [SW-1:0] ch_next;
  logic          wrap_next, err_next;
  logic [W-1:0]  mux_out;

  mux_nx1 #(.N(N), .W(W), .SW(SW)) u_mux (
    .in  (in),
    .idx (ch),
    .out (mux_out)
  );

  // The dwell counter is only live in scan mode; direct mode keeps it at zero so
  // that entering scan always grants the current channel a full dwell.
  always_comb begin
    ch_next   = ch;
    cnt_next  = '0;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    if (mode == MODE_SCAN) begin
      if (cnt == LAST_CNT) begin
        if (ch == LAST_CH) begin
          ch_next   = '0;
          wrap_next = 1'b1;
        end else begin
          ch_next = ch + 1'b1;
        end
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end else if (load) begin
      if ({1'b0, sel} < N_EXT) ch_next = sel;
      else                     err_next = 1'b1;
    end
  end

  // out always lags ch by one cycle, so it is only valid when ch did not move.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch        <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      ch        <= ch_next;
      cnt       <= cnt_next;
      out       <= mux_out;
      out_valid <= (ch_next == ch);
      wrap      <= wrap_next;
      sel_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_mux_seq_nx1.sv
// Bench for mux_seq_nx1: two configurations (N=12/DWELL=3 and N=5/DWELL=1) with a queued reference model.
module tb_mux_seq_nx1;

  localparam int NA = 12, DA = 3;
  localparam int NB = 5,  DB = 1;

  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, load = 1'b0;
  logic [3:0] sel_a = '0;
  logic [2:0] sel_b = '0;
  logic [NA*8-1:0] in_a;
  logic [NB*8-1:0] in_b;

  logic [7:0] out_a, out_b;
  logic [3:0] ch_a;
  logic [2:0] ch_b;
  logic valid_a, valid_b, wrap_a, wrap_b, err_a, err_b;

  int errors = 0, checks = 0;
  int m_ch[2], m_spent[2];
  logic [18:0] exp_q_a[$], exp_q_b[$];
  logic [18:0] e_a, e_b;

  mux_seq_nx1 #(.N(NA), .W(8), .DWELL(DA)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .sel(sel_a), .load(load), .mode(mode),
    .out(out_a), .out_valid(valid_a), .ch(ch_a), .wrap(wrap_a), .sel_err(err_a)
  );

  mux_seq_nx1 #(.N(NB), .W(8), .DWELL(DB)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .sel(sel_b), .load(load), .mode(mode),
    .out(out_b), .out_valid(valid_b), .ch(ch_b), .wrap(wrap_b), .sel_err(err_b)
  );

  always #5 clk = ~clk;

  // Reference: channel index plus cycles spent on it; result packs {ch, out, valid, wrap, sel_err}.
  function automatic logic [18:0] model_step(input int i, input int n, input int dw, input bit r,
                                             input bit md, input bit ld, input int s,
                                             input logic [95:0] inv);
    int nch;
    logic [7:0] o;
    bit v, wr, er;
    o = inv[m_ch[i]*8 +: 8];
    if (r) begin
      m_ch[i] = 0;
      m_spent[i] = 0;
      return 19'b0;
    end
    nch = m_ch[i];
    wr = 1'b0;
    er = 1'b0;
    if (!md) begin
      m_spent[i] = 0;
      if (ld) begin
        if (s < n) nch = s;
        else       er = 1'b1;
      end
    end else begin
      m_spent[i] = m_spent[i] + 1;
      if (m_spent[i] == dw) begin
        m_spent[i] = 0;
        nch = (m_ch[i] + 1) % n;
        wr = (nch == 0);
      end
    end
    v = (nch == m_ch[i]);
    m_ch[i] = nch;
    return {8'(nch), o, v, wr, er};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_bundle(input string nm, input logic [7:0] c, input logic [7:0] o,
                            input logic v, input logic w, input logic er, input logic [18:0] e);
    chk({nm, "_ch"}, 32'(c), 32'(e[18:11]));
    chk({nm, "_out"}, 32'(o), 32'(e[10:3]));
    chk({nm, "_valid"}, 32'(v), 32'(e[2]));
    chk({nm, "_wrap"}, 32'(w), 32'(e[1]));
    chk({nm, "_sel_err"}, 32'(er), 32'(e[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard producer: every active edge yields one expected output set per DUT.
  always @(posedge clk) begin
    exp_q_a.push_back(model_step(0, NA, DA, rst, mode, load, int'(sel_a), 96'(in_a)));
    exp_q_b.push_back(model_step(1, NB, DB, rst, mode, load, int'(sel_b), 96'(in_b)));
  end

  // Monitor: compare registered outputs mid-cycle against the queue head.
  always @(negedge clk) begin
    if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
      errors++;
      $display("FAIL monitor: expected queue empty at %0t", $time);
    end else begin
      e_a = exp_q_a.pop_front();
      e_b = exp_q_b.pop_front();
      cmp_bundle("a", {4'b0, ch_a}, out_a, valid_a, wrap_a, err_a, e_a);
      cmp_bundle("b", {5'b0, ch_b}, out_b, valid_b, wrap_b, err_b, e_b);
    end
  end

  initial begin
    for (int k = 0; k < NA; k++) in_a[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < NB; k++) in_b[k*8 +: 8] = 8'(8'h10 + k);

    tick();
    tick();
    chk("reset_ch", 32'(ch_a), 0);
    chk("reset_out", 32'(out_a), 0);
    chk("reset_valid", 32'(valid_a), 0);

    rst = 1'b0; load = 1'b1; sel_a = 4'd5; sel_b = 3'd3;
    tick();
    chk("load_ch", 32'(ch_a), 5);
    chk("load_valid_gap", 32'(valid_a), 0);
    chk("load_ch_b", 32'(ch_b), 3);
    load = 1'b0;
    tick();
    chk("load_out", 32'(out_a), 32'h15);
    chk("load_valid", 32'(valid_a), 1);
    chk("load_out_b", 32'(out_b), 32'h13);

    load = 1'b1; sel_a = 4'd13; sel_b = 3'd6;
    tick();
    chk("oor_err", 32'(err_a), 1);
    chk("oor_hold", 32'(ch_a), 5);
    chk("oor_err_b", 32'(err_b), 1);
    chk("oor_hold_b", 32'(ch_b), 3);
    load = 1'b0;
    tick();
    chk("oor_pulse_end", 32'(err_a), 0);
    load = 1'b1; sel_a = 4'd11;
    tick();
    load = 1'b0;
    tick();
    chk("last_out", 32'(out_a), 32'h1b);
    chk("last_valid", 32'(valid_a), 1);

    load = 1'b1; sel_a = 4'd0; sel_b = 3'd0;
    tick();
    load = 1'b0; mode = 1'b1;
    for (int k = 1; k <= 43; k++) begin
      load = 1'($urandom_range(0, 1));
      sel_a = 4'($urandom_range(0, 15));
      tick();
      chk("scan_ch", 32'(ch_a), 32'((k / DA) % NA));
      chk("scan_wrap", 32'(wrap_a), 32'(k == 36));
      chk("scan_valid", 32'(valid_a), 32'(k % DA != 0));
      chk("scan_err", 32'(err_a), 0);
      chk("d1_ch", 32'(ch_b), 32'(k % NB));
      chk("d1_valid", 32'(valid_b), 0);
      chk("d1_wrap", 32'(wrap_b), 32'(k % NB == 0));
    end

    mode = 1'b0; load = 1'b1; sel_a = 4'd7;
    tick();
    chk("switch_load", 32'(ch_a), 7);
    mode = 1'b1; load = 1'b0;
    tick();
    chk("rescan_hold1", 32'(ch_a), 7);
    tick();
    chk("rescan_hold2", 32'(ch_a), 7);
    tick();
    chk("rescan_adv", 32'(ch_a), 8);

    mode = 1'b0; load = 1'b1; sel_a = 4'd3;
    tick();
    mode = 1'b1; load = 1'b0;
    tick();
    chk("pre_rst_ch", 32'(ch_a), 3);
    rst = 1'b1;
    tick();
    chk("midrst_ch", 32'(ch_a), 0);
    chk("midrst_out", 32'(out_a), 0);
    chk("midrst_valid", 32'(valid_a), 0);
    chk("midrst_wrap", 32'(wrap_a), 0);
    rst = 1'b0;
    tick();
    chk("rst_dwell1", 32'(ch_a), 0);
    tick();
    chk("rst_dwell2", 32'(ch_a), 0);
    tick();
    chk("rst_dwell_adv", 32'(ch_a), 1);

    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      load = ($urandom_range(0, 3) == 0);
      sel_a = 4'($urandom_range(0, 15));
      sel_b = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < NA; k++) in_a[k*8 +: 8] = 8'($urandom_range(0, 255));
      for (int k = 0; k < NB; k++) in_b[k*8 +: 8] = 8'($urandom_range(0, 255));
      tick();
    end

    rst = 1'b0; load = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
